// File: rtl/ats_cmd_ingress.sv
`default_nettype none
// ============================================================================
// Module   : ats_cmd_ingress
// Purpose  : Two-word command assembly per client, NOP filtering, round-robin
//            arbitration into a tagged FIFO towards the ATS decode core.
// Revision : 1.0 - initial release
// ============================================================================
module ats_cmd_ingress #(
    parameter  int N_CLIENTS = 2,
    parameter  int WORD_W    = 16,
    parameter  int DEPTH     = 4,
    parameter  int OPC_W     = 3,
    localparam int CMD_W     = 2 * WORD_W,
    localparam int SRC_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
    localparam int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIENTS-1:0]        req,
    input  logic [N_CLIENTS*WORD_W-1:0] ctrl,
    output logic [N_CLIENTS-1:0]        client_busy,
    output logic [N_CLIENTS-1:0]        ovf,
    input  logic [N_CLIENTS-1:0]        ovf_clr,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [CMD_W-1:0]            cmd_data,
    output logic [SRC_W-1:0]            cmd_src,
    output logic [LVL_W-1:0]            fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = SRC_W + CMD_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOW  = 1'b1;

    logic [N_CLIENTS-1:0] w_hold_full;
    logic [CMD_W-1:0]     w_hold_data [N_CLIENTS];
    logic [N_CLIENTS-1:0] w_grant;
    logic [SRC_W-1:0]     w_cand      [N_CLIENTS];
    logic [SRC_W-1:0]     w_grant_idx;
    logic                 w_grant_any;
    logic [SRC_W-1:0]     r_rr_ptr;

    logic [ENT_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [ENT_W-1:0]     w_head;
    logic                 w_fifo_full;
    logic                 w_push;
    logic                 w_pop;

    // ------------------------------------------------------------------------
    // Per-client assembler and holding register
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N_CLIENTS; k++) begin : g_client
        logic [0:0]        r_state;
        logic [WORD_W-1:0] r_hi_word;
        logic [CMD_W-1:0]  r_hold_data;
        logic              r_hold_full;
        logic              r_ovf;
        logic [WORD_W-1:0] w_word;
        logic [CMD_W-1:0]  w_cmd;
        logic              w_keep;
        logic              w_load;
        logic              w_drop;

        assign w_word = ctrl[k*WORD_W +: WORD_W];
        assign w_cmd  = {r_hi_word, w_word};
        assign w_keep = (r_state == S_LOW) && (r_hi_word[WORD_W-1 -: OPC_W] != '0);
        // A holding register being granted this cycle frees up in time for the load.
        assign w_load = w_keep && (!r_hold_full || w_grant[k]);
        assign w_drop = w_keep && r_hold_full && !w_grant[k];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state     <= S_IDLE;
                r_hi_word   <= '0;
                r_hold_data <= '0;
                r_hold_full <= 1'b0;
                r_ovf       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (req[k]) begin
                            r_hi_word <= w_word;
                            r_state   <= S_LOW;
                        end
                    end
                    S_LOW:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase

                if (w_load) begin
                    r_hold_data <= w_cmd;
                    r_hold_full <= 1'b1;
                end else if (w_grant[k]) begin
                    r_hold_full <= 1'b0;
                end

                if (w_drop) begin
                    r_ovf <= 1'b1;
                end else if (ovf_clr[k]) begin
                    r_ovf <= 1'b0;
                end
            end
        end

        assign w_hold_full[k] = r_hold_full;
        assign w_hold_data[k] = r_hold_data;
        assign ovf[k]         = r_ovf;
        assign client_busy[k] = (r_state == S_LOW) | r_hold_full;
    end

    // ------------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_cand
        assign w_cand[i] = SRC_W'((int'(r_rr_ptr) + i) % N_CLIENTS);
    end

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (!w_fifo_full) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (!w_grant_any && w_hold_full[w_cand[i]]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = w_cand[i];
                end
            end
        end
    end

    assign w_grant = w_grant_any ? (N_CLIENTS'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr <= (w_grant_idx == SRC_W'(N_CLIENTS - 1)) ? '0 : w_grant_idx + SRC_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    // Grants are gated on the registered level, so a pop from a full FIFO
    // only opens a slot for the following cycle.
    assign w_fifo_full = (r_level == LVL_W'(DEPTH));
    assign w_push      = w_grant_any;
    assign w_pop       = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_grant_idx, w_hold_data[w_grant_idx]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign cmd_valid  = (r_level != '0);
    assign cmd_data   = cmd_valid ? w_head[CMD_W-1:0] : '0;
    assign cmd_src    = cmd_valid ? w_head[ENT_W-1 -: SRC_W] : '0;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_ats_cmd_ingress.sv
`default_nettype none
// ============================================================================
// Module   : tb_ats_cmd_ingress
// Purpose  : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ats_cmd_ingress;

    localparam int N     = 2;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int OPC_W = 3;
    localparam int CMD_W = 2 * W;
    localparam int SRC_W = 1;
    localparam int LVL_W = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req;
    logic [N*W-1:0]     ctrl;
    logic [N-1:0]       client_busy;
    logic [N-1:0]       ovf;
    logic [N-1:0]       ovf_clr;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [CMD_W-1:0]   cmd_data;
    logic [SRC_W-1:0]   cmd_src;
    logic [LVL_W-1:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    ats_cmd_ingress #(
        .N_CLIENTS (N),
        .WORD_W    (W),
        .DEPTH     (DEPTH),
        .OPC_W     (OPC_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ctrl        (ctrl),
        .client_busy (client_busy),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_src     (cmd_src),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Reference model: FIFO as a queue, one holding slot and one phase bit per client.
    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [CMD_W-1:0] data;
    } ent_t;

    ent_t             m_q[$];
    logic [N-1:0]     m_low;
    logic [N-1:0]     m_hv;
    logic [N-1:0]     m_ovf;
    logic [W-1:0]     m_hi [N];
    logic [CMD_W-1:0] m_hd [N];
    int               m_rr;

    task automatic model_reset();
        m_q.delete();
        m_low = '0;
        m_hv  = '0;
        m_ovf = '0;
        m_rr  = 0;
        for (int k = 0; k < N; k++) begin
            m_hi[k] = '0;
            m_hd[k] = '0;
        end
    endtask

    task automatic model_step();
        int g;
        logic [CMD_W-1:0] c;
        g = -1;
        if (m_q.size() < DEPTH) begin
            for (int i = 0; i < N; i++) begin
                int cand;
                cand = (m_rr + i) % N;
                if (g < 0 && m_hv[cand]) g = cand;
            end
        end
        if (m_q.size() != 0 && cmd_ready) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back('{src: SRC_W'(g), data: m_hd[g]});
            m_hv[g] = 1'b0;
            m_rr = (g + 1) % N;
        end
        for (int k = 0; k < N; k++) begin
            if (ovf_clr[k]) m_ovf[k] = 1'b0;
            if (m_low[k]) begin
                c = {m_hi[k], ctrl[k*W +: W]};
                m_low[k] = 1'b0;
                if (c[CMD_W-1 -: OPC_W] != '0) begin
                    if (!m_hv[k]) begin
                        m_hv[k] = 1'b1;
                        m_hd[k] = c;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
            end else if (req[k]) begin
                m_hi[k]  = ctrl[k*W +: W];
                m_low[k] = 1'b1;
            end
        end
    endtask

    // Advance one clock: model follows the rising edge, bench resumes on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tick();
        tick();
        checks++;
        if ({cmd_valid, fifo_level, client_busy, ovf, cmd_src, cmd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b lvl=%0d busy=%b ovf=%b src=%0d data=%h, expected all 0",
                     cmd_valid, fifo_level, client_busy, ovf, cmd_src, cmd_data);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({cmd_valid, fifo_level, client_busy, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_release: got valid=%0b lvl=%0d busy=%b ovf=%b, expected all 0",
                     cmd_valid, fifo_level, client_busy, ovf);
        end
    endtask

    task automatic test_simultaneous();
        cmd_ready = 1'b1;
        req  = 2'b11;
        ctrl = {16'h2240, 16'h2000};
        tick();
        req  = 2'b00;
        ctrl = {16'h0000, 16'h0000};
        tick();
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_latency: valid=%0b one cycle after low word, expected 0", cmd_valid);
        end
        tick();
        checks++;
        if ({cmd_valid, cmd_src, cmd_data} !== {1'b1, 1'b0, 32'h2000_0000}) begin
            errors++;
            $display("FAIL t1_first: got valid=%0b src=%0d data=%h, expected 1/0/20000000",
                     cmd_valid, cmd_src, cmd_data);
        end
        tick();
        checks++;
        if ({cmd_valid, cmd_src, cmd_data} !== {1'b1, 1'b1, 32'h2240_0000}) begin
            errors++;
            $display("FAIL t1_second: got valid=%0b src=%0d data=%h, expected 1/1/22400000",
                     cmd_valid, cmd_src, cmd_data);
        end
        tick();
        checks++;
        if ({cmd_valid, fifo_level} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL t1_empty: got valid=%0b lvl=%0d, expected 0/0", cmd_valid, fifo_level);
        end
    endtask

    task automatic test_fairness();
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req  = 2'b11;
            ctrl = {16'h5000, 16'h3000};
            tick();
            req  = 2'b00;
            ctrl = {16'(16'h0B00 + i), 16'(16'h0A00 + i)};
            tick();
        end
        ctrl = '0;
        checks++;
        if ({fifo_level, client_busy, ovf} !== {3'd4, 2'b11, 2'b00}) begin
            errors++;
            $display("FAIL t4_full: got lvl=%0d busy=%b ovf=%b, expected 4/11/00",
                     fifo_level, client_busy, ovf);
        end
        cmd_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            logic [CMD_W-1:0] exp_d;
            exp_d = (j % 2 == 0) ? 32'h3000_0A00 + 32'(j / 2) : 32'h5000_0B00 + 32'(j / 2);
            checks++;
            if ({cmd_valid, cmd_src, cmd_data} !== {1'b1, SRC_W'(j % 2), exp_d}) begin
                errors++;
                $display("FAIL t4_order[%0d]: got valid=%0b src=%0d data=%h, expected 1/%0d/%h",
                         j, cmd_valid, cmd_src, cmd_data, j % 2, exp_d);
            end
            tick();
        end
        checks++;
        if ({cmd_valid, fifo_level, client_busy} !== {1'b0, 3'd0, 2'b00}) begin
            errors++;
            $display("FAIL t4_drained: got valid=%0b lvl=%0d busy=%b, expected 0/0/00",
                     cmd_valid, fifo_level, client_busy);
        end
    endtask

    task automatic test_nop();
        req  = 2'b01;
        ctrl = {16'h0000, 16'h0000};
        tick();
        checks++;
        if (client_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL t2_busy_on: got busy0=%0b, expected 1", client_busy[0]);
        end
        req  = 2'b00;
        ctrl = {16'h0000, 16'h1234};
        tick();
        ctrl = '0;
        checks++;
        if (client_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL t2_busy_off: got busy0=%0b, expected 0", client_busy[0]);
        end
        tick();
        checks++;
        if ({cmd_valid, fifo_level, ovf} !== {1'b0, 3'd0, 2'b00}) begin
            errors++;
            $display("FAIL t2_no_push: got valid=%0b lvl=%0d ovf=%b, expected 0/0/00",
                     cmd_valid, fifo_level, ovf);
        end
    endtask

    task automatic test_backpressure();
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req  = 2'b01;
            ctrl = {16'h0000, 16'hA080};
            tick();
            req  = 2'b00;
            ctrl = {16'h0000, 16'(16'h0025 + i)};
            tick();
        end
        ctrl = '0;
        checks++;
        if ({cmd_valid, fifo_level, client_busy[0], ovf[0]} !== {1'b1, 3'd4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL t3_full: got valid=%0b lvl=%0d busy0=%0b ovf0=%0b, expected 1/4/1/1",
                     cmd_valid, fifo_level, client_busy[0], ovf[0]);
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({cmd_valid, cmd_src, cmd_data} !== {1'b1, 1'b0, 32'hA080_0025 + 32'(i)}) begin
                errors++;
                $display("FAIL t3_drain[%0d]: got valid=%0b src=%0d data=%h, expected 1/0/%h",
                         i, cmd_valid, cmd_src, cmd_data, 32'hA080_0025 + 32'(i));
            end
            tick();
        end
        checks++;
        if ({cmd_valid, fifo_level} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL t3_empty: got valid=%0b lvl=%0d, expected 0/0", cmd_valid, fifo_level);
        end
    endtask

    task automatic test_ovf_clr();
        ovf_clr = 2'b01;
        tick();
        ovf_clr = 2'b00;
        checks++;
        if (ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL t6_clear: got ovf0=%0b, expected 0", ovf[0]);
        end
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req  = 2'b01;
            ctrl = {16'h0000, 16'hA080};
            tick();
            req  = 2'b00;
            ctrl = {16'h0000, 16'(16'h0040 + i)};
            tick();
        end
        checks++;
        if ({fifo_level, ovf[0]} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL t6_prefill: got lvl=%0d ovf0=%0b, expected 4/0", fifo_level, ovf[0]);
        end
        req  = 2'b01;
        ctrl = {16'h0000, 16'hA080};
        tick();
        req     = 2'b00;
        ctrl    = {16'h0000, 16'h0045};
        ovf_clr = 2'b01;
        tick();
        ovf_clr = 2'b00;
        ctrl    = '0;
        checks++;
        if (ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL t6_set_wins: got ovf0=%0b, expected 1", ovf[0]);
        end
        cmd_ready = 1'b1;
        repeat (8) tick();
        ovf_clr = 2'b01;
        tick();
        ovf_clr = 2'b00;
        checks++;
        if ({fifo_level, client_busy, ovf} !== {3'd0, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL t6_cleanup: got lvl=%0d busy=%b ovf=%b, expected 0/00/00",
                     fifo_level, client_busy, ovf);
        end
    endtask

    task automatic test_reset_mid();
        cmd_ready = 1'b0;
        req  = 2'b10;
        ctrl = {16'h7000, 16'h0000};
        tick();
        req  = 2'b00;
        ctrl = {16'h0011, 16'h0000};
        tick();
        req  = 2'b01;
        ctrl = {16'h0000, 16'h4000};
        tick();
        checks++;
        if ({cmd_valid, fifo_level, client_busy} !== {1'b1, 3'd1, 2'b01}) begin
            errors++;
            $display("FAIL t5_pre: got valid=%0b lvl=%0d busy=%b, expected 1/1/01",
                     cmd_valid, fifo_level, client_busy);
        end
        req  = 2'b00;
        ctrl = {16'h0000, 16'h0077};
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, fifo_level, client_busy, ovf, cmd_src, cmd_data} !== '0) begin
            errors++;
            $display("FAIL t5_async: got valid=%0b lvl=%0d busy=%b ovf=%b src=%0d data=%h, expected all 0",
                     cmd_valid, fifo_level, client_busy, ovf, cmd_src, cmd_data);
        end
        tick();
        reset = 1'b1;
        ctrl  = '0;
        repeat (3) tick();
        checks++;
        if ({cmd_valid, fifo_level, client_busy, ovf} !== '0) begin
            errors++;
            $display("FAIL t5_lost: got valid=%0b lvl=%0d busy=%b ovf=%b, expected all 0",
                     cmd_valid, fifo_level, client_busy, ovf);
        end
        cmd_ready = 1'b1;
        req  = 2'b01;
        ctrl = {16'h0000, 16'h6000};
        tick();
        req  = 2'b00;
        ctrl = {16'h0000, 16'h0099};
        tick();
        ctrl = '0;
        tick();
        checks++;
        if ({cmd_valid, cmd_src, cmd_data} !== {1'b1, 1'b0, 32'h6000_0099}) begin
            errors++;
            $display("FAIL t5_after: got valid=%0b src=%0d data=%h, expected 1/0/60000099",
                     cmd_valid, cmd_src, cmd_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic             exp_valid;
            logic [LVL_W-1:0] exp_level;
            exp_valid = (m_q.size() != 0);
            exp_level = LVL_W'(m_q.size());
            checks++;
            if ({cmd_valid, fifo_level, client_busy, ovf} !== {exp_valid, exp_level, m_low | m_hv, m_ovf}) begin
                errors++;
                $display("FAIL rand_status@%0d: got valid=%0b lvl=%0d busy=%b ovf=%b, expected %0b/%0d/%b/%b",
                         cyc, cmd_valid, fifo_level, client_busy, ovf,
                         exp_valid, exp_level, m_low | m_hv, m_ovf);
            end
            if (exp_valid) begin
                checks++;
                if ({cmd_src, cmd_data} !== m_q[0]) begin
                    errors++;
                    $display("FAIL rand_head@%0d: got src=%0d data=%h, expected src=%0d data=%h",
                             cyc, cmd_src, cmd_data, m_q[0].src, m_q[0].data);
                end
            end
            cmd_ready = ((cyc / 150) % 2 == 1) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
            for (int k = 0; k < N; k++) begin
                req[k]          = ($urandom % 3 == 0);
                ctrl[k*W +: W]  = W'($urandom);
                ovf_clr[k]      = ($urandom % 20 == 0);
            end
            tick();
        end
        req     = '0;
        ctrl    = '0;
        ovf_clr = '0;
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        ctrl      = '0;
        ovf_clr   = '0;
        cmd_ready = 1'b0;
        model_reset();
        test_reset();
        test_simultaneous();
        test_fairness();
        test_nop();
        test_backpressure();
        test_ovf_clr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
